// File: rtl/pcs_fifo_pkg.sv
// rtl/pcs_fifo_pkg.sv - shared sizing helpers and flag indices for the PCS sync FIFO
//
// Purpose: constant functions that size pointers from DEPTH, plus the bit
//          positions of the status flags inside the FIFO's internal flag vector.
// Ports:   none (package).

package pcs_fifo_pkg;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointer width: address bits plus one wrap bit, so full and empty differ.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  localparam int FLAG_AF    = 0;
  localparam int FLAG_AE    = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_UDF   = 3;
  localparam int FLAG_COUNT = 4;

endpackage

// File: rtl/pcs_sync_fifo_if.sv
// rtl/pcs_sync_fifo_if.sv - datapath handshake and status bundle for the PCS sync FIFO
//
// Purpose: groups write/read handshake, head data, level and flags.
// Signals: in_data/in_datavalid (write side), in_idle (downstream ready),
//          out_idle/out_data/out_datavalid (handshake back), out_level and the
//          almost/sticky flags (status).
// Modports: master = the upstream/downstream user, slave = the FIFO itself.

interface pcs_sync_fifo_if
  import pcs_fifo_pkg::*;
#(
  parameter int WIDTH = 192,
  parameter int DEPTH = 8
);
  localparam int LW = ptr_width(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             in_datavalid;
  logic             in_idle;
  logic             out_idle;
  logic [WIDTH-1:0] out_data;
  logic             out_datavalid;
  logic [LW-1:0]    out_level;
  logic             out_almost_full;
  logic             out_almost_empty;
  logic             out_overflow;
  logic             out_underflow;

  modport master (
    output in_data, in_datavalid, in_idle,
    input  out_idle, out_data, out_datavalid, out_level,
           out_almost_full, out_almost_empty, out_overflow, out_underflow
  );

  modport slave (
    input  in_data, in_datavalid, in_idle,
    output out_idle, out_data, out_datavalid, out_level,
           out_almost_full, out_almost_empty, out_overflow, out_underflow
  );

endinterface

// File: rtl/pcs_fifo_mem.sv
// rtl/pcs_fifo_mem.sv - DEPTH x WIDTH register array, one write port, async read port
//
// Purpose: storage for the PCS sync FIFO; cleared by reset so the head word
//          reads as zero out of reset.
// Ports:   clk, reset_n (sync, active-low); wr_en/wr_addr/wr_data write port;
//          rd_addr -> rd_data combinational read port.

module pcs_fifo_mem #(
  parameter int WIDTH = 192,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pcs_sync_fifo.sv
// rtl/pcs_sync_fifo.sv - single-clock FWFT FIFO with level, almost flags and sticky errors
//
// Purpose: rate/latency buffer between PCS stages on one clock.
// Ports:   clk; reset_n (sync, active-low); in_enable (0 freezes all state);
//          in_flush (sync empty + sticky clear); bus (slave modport): write
//          handshake, downstream ready, FWFT head data, level and flags.

module pcs_sync_fifo
  import pcs_fifo_pkg::*;
#(
  parameter int WIDTH     = 192,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_enable,
  input  logic                 in_flush,
  pcs_sync_fifo_if.slave       bus
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = ptr_width(DEPTH);
  localparam logic [LW-1:0] AF_LVL = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LVL = LW'(AE_THRESH);

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("pcs_sync_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_check
    $error("pcs_sync_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_check
    $error("pcs_sync_fifo: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [LW-1:0]         wr_ptr;
  logic [LW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  empty;
  logic                  full;
  logic                  wr;
  logic                  rd;
  logic                  ovf_evt;
  logic                  udf_evt;
  logic                  ovf_q;
  logic                  udf_q;
  logic [FLAG_COUNT-1:0] flags;
  logic [WIDTH-1:0]      head;

  // The wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level = wr_ptr - rd_ptr;

  // A write into a full FIFO is taken only when a read frees the head slot
  // in the same cycle. No bypass on empty: the read is simply blocked.
  assign rd = in_enable && bus.in_idle && !empty;
  assign wr = in_enable && bus.in_datavalid && (!full || rd);

  assign ovf_evt = in_enable && bus.in_datavalid && full && !rd;
  assign udf_evt = in_enable && bus.in_idle && empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (in_enable && in_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (ovf_evt) ovf_q <= 1'b1;
      if (udf_evt) udf_q <= 1'b1;
    end
  end

  // Flushed writes must not land in storage; the array keeps old contents.
  pcs_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr && !in_flush),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (head)
  );

  assign flags[FLAG_AF]  = (level >= AF_LVL);
  assign flags[FLAG_AE]  = (level <= AE_LVL);
  assign flags[FLAG_OVF] = ovf_q;
  assign flags[FLAG_UDF] = udf_q;

  assign bus.out_idle         = !full;
  assign bus.out_data         = head;
  assign bus.out_datavalid    = bus.in_idle && !empty;
  assign bus.out_level        = level;
  assign bus.out_almost_full  = flags[FLAG_AF];
  assign bus.out_almost_empty = flags[FLAG_AE];
  assign bus.out_overflow     = flags[FLAG_OVF];
  assign bus.out_underflow    = flags[FLAG_UDF];

`ifdef PCS_SIM
  // A write offered to a full FIFO with no read must be recorded as overflow.
  property p_full_write_overflow;
    @(posedge clk) disable iff (!reset_n)
      (in_enable && !in_flush && bus.in_datavalid && !bus.out_idle && !bus.in_idle)
      |=> ovf_q;
  endproperty
  a_full_write_overflow: assert property (p_full_write_overflow)
    else $error("pcs_sync_fifo: write dropped while full without overflow flag");
`endif

endmodule

// File: tb/tb_pcs_sync_fifo.sv
// tb/tb_pcs_sync_fifo.sv - scoreboard bench for pcs_sync_fifo (DEPTH 8, WIDTH 192)

module tb_pcs_sync_fifo;

  localparam int W = 192;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic in_enable;
  logic in_flush;

  always #5 clk = ~clk;

  pcs_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pcs_sync_fifo #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_enable (in_enable),
    .in_flush  (in_flush),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int msz;
  bit mon_on = 1'b0;
  bit last_acc;
  bit m_ovf  = 1'b0;
  bit m_udf  = 1'b0;
  logic [W-1:0] q [$];
  logic [W-1:0] exp_word;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int k);
    return {32'hC0DE0000 | 32'(k), 32'(~k), 64'(k * 7 + 3), 64'(k)};
  endfunction

  // Drive one cycle of stimulus, predict the FIFO's response and record it
  // in the scoreboard queue once the edge has happened.
  task automatic step(input bit rn, input bit en, input bit fl, input bit dv,
                      input bit idle, input logic [W-1:0] d);
    int  sz;
    bit  rd_p, wr_p, ovf_p, udf_p;
    reset_n          = rn;
    in_enable        = en;
    in_flush         = fl;
    bus.in_datavalid = dv;
    bus.in_idle      = idle;
    bus.in_data      = d;
    sz    = q.size();
    rd_p  = en && idle && (sz != 0);
    wr_p  = en && dv && ((sz != D) || rd_p);
    ovf_p = en && dv && (sz == D) && !rd_p;
    udf_p = en && idle && (sz == 0);
    last_acc = rn && !(en && fl) && wr_p;
    @(posedge clk);
    if (!rn || (en && fl)) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr_p) q.push_back(d);
      if (ovf_p) m_ovf = 1'b1;
      if (udf_p) m_udf = 1'b1;
    end
    #1;
  endtask

  // Monitor: compares status against the scoreboard every cycle and pops the
  // expected head whenever the DUT presents a word that is being consumed.
  always @(negedge clk) begin
    if (mon_on) begin
      msz = q.size();
      chk("mon_level", W'(bus.out_level), W'(msz));
      chk("mon_datavalid", W'(bus.out_datavalid), W'(bus.in_idle && (msz != 0)));
      chk("mon_idle", W'(bus.out_idle), W'(msz != D));
      chk("mon_af", W'(bus.out_almost_full), W'(msz >= 6));
      chk("mon_ae", W'(bus.out_almost_empty), W'(msz <= 1));
      chk("mon_ovf", W'(bus.out_overflow), W'(m_ovf));
      chk("mon_udf", W'(bus.out_underflow), W'(m_udf));
      if (reset_n && in_enable && !in_flush && bus.in_idle && (msz != 0)) begin
        exp_word = q.pop_front();
        chk("mon_data", bus.out_data, exp_word);
        pops++;
      end
    end
  end

  initial begin
    int k;
    int p0;

    // 1: reset
    step(0, 1, 0, 0, 1, '0);
    step(0, 1, 0, 0, 1, '0);
    chk("rst_level", W'(bus.out_level), 0);
    chk("rst_idle", W'(bus.out_idle), 1);
    chk("rst_datavalid", W'(bus.out_datavalid), 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ae", W'(bus.out_almost_empty), 1);
    chk("rst_af", W'(bus.out_almost_full), 0);
    chk("rst_ovf", W'(bus.out_overflow), 0);
    chk("rst_udf", W'(bus.out_underflow), 0);
    mon_on = 1'b1;

    // 2: fill to full, overflow on 9th, drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 0, 1, 0, W'(i));
      chk("fill_level", W'(bus.out_level), W'(i));
      chk("fill_af", W'(bus.out_almost_full), W'(i >= 6));
    end
    chk("full_idle", W'(bus.out_idle), 0);
    step(1, 1, 0, 1, 0, W'(9));
    chk("ovf_set", W'(bus.out_overflow), 1);
    chk("ovf_level", W'(bus.out_level), 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", bus.out_data, W'(i));
      step(1, 1, 0, 0, 1, '0);
    end
    chk("drain_level", W'(bus.out_level), 0);
    chk("drain_ovf_sticky", W'(bus.out_overflow), 1);
    step(1, 1, 0, 0, 1, '0);
    chk("udf_set", W'(bus.out_underflow), 1);

    // 3: full with simultaneous write and read
    step(1, 1, 1, 0, 0, '0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0, W'(32'h100 + i));
    step(1, 1, 0, 1, 1, W'(32'h55));
    chk("slot_reuse_level", W'(bus.out_level), 8);
    chk("slot_reuse_ovf", W'(bus.out_overflow), 0);
    chk("slot_reuse_head", bus.out_data, W'(32'h101));
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 1, '0);
    chk("slot_reuse_drained", W'(bus.out_level), 0);

    // 4: 1000-word stream with random downstream ready
    step(1, 1, 1, 0, 0, '0);
    k  = 0;
    p0 = pops;
    for (int c = 0; c < 8000 && !(k >= 1000 && q.size() == 0); c++) begin
      step(1, 1, 0, (k < 1000), 1'($urandom_range(0, 1)), mk(k));
      if (last_acc) k++;
    end
    chk("stream_sent", W'(k), 1000);
    chk("stream_popped", W'(pops - p0), 1000);
    chk("stream_level", W'(bus.out_level), 0);

    // 5: flush at level 5
    step(1, 1, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, W'(32'h200 + i));
    chk("pre_flush_level", W'(bus.out_level), 5);
    step(1, 1, 1, 1, 1, W'(32'hBAD));
    chk("flush_level", W'(bus.out_level), 0);
    chk("flush_datavalid", W'(bus.out_datavalid), 0);
    chk("flush_ovf", W'(bus.out_overflow), 0);
    chk("flush_udf", W'(bus.out_underflow), 0);
    chk("flush_ae", W'(bus.out_almost_empty), 1);

    // 6: enable low freezes state, then reset mid-stream
    step(1, 1, 0, 0, 1, '0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, W'(32'hA + i));
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1, W'(32'hEE));
      chk("hold_level", W'(bus.out_level), 3);
      chk("hold_head", bus.out_data, W'(32'hA));
      chk("hold_udf", W'(bus.out_underflow), 1);
      chk("hold_ae", W'(bus.out_almost_empty), 0);
    end
    step(0, 1, 0, 1, 1, W'(32'h77));
    chk("mid_rst_level", W'(bus.out_level), 0);
    chk("mid_rst_idle", W'(bus.out_idle), 1);
    chk("mid_rst_datavalid", W'(bus.out_datavalid), 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_ae", W'(bus.out_almost_empty), 1);
    chk("mid_rst_udf", W'(bus.out_underflow), 0);
    step(1, 1, 0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
